// File: rtl/zigzag_pp.sv
// zigzag_pp: double-buffered 8x8 coefficient reorder between column-major and JPEG zig-zag order.
// Two 64-entry banks ping-pong so one block streams in while the previous block streams out.
module zigzag_pp #(
    parameter int DATA_W = 11,
    parameter int MODE_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_in,
    output logic              rdy_out,
    input  logic [DATA_W-1:0] in,
    input  logic [MODE_W-1:0] mode,
    output logic              ena_out,
    input  logic              rdy_in,
    output logic [DATA_W-1:0] out,
    output logic              out_last
);

    // Column-major address held in each zig-zag slot.
    function automatic logic [5:0] zz(input logic [5:0] k);
        logic [5:0] a;
        case (k)
            6'd0:  a = 6'd0;  6'd1:  a = 6'd8;  6'd2:  a = 6'd1;  6'd3:  a = 6'd2;
            6'd4:  a = 6'd9;  6'd5:  a = 6'd16; 6'd6:  a = 6'd24; 6'd7:  a = 6'd17;
            6'd8:  a = 6'd10; 6'd9:  a = 6'd3;  6'd10: a = 6'd4;  6'd11: a = 6'd11;
            6'd12: a = 6'd18; 6'd13: a = 6'd25; 6'd14: a = 6'd32; 6'd15: a = 6'd40;
            6'd16: a = 6'd33; 6'd17: a = 6'd26; 6'd18: a = 6'd19; 6'd19: a = 6'd12;
            6'd20: a = 6'd5;  6'd21: a = 6'd6;  6'd22: a = 6'd13; 6'd23: a = 6'd20;
            6'd24: a = 6'd27; 6'd25: a = 6'd34; 6'd26: a = 6'd41; 6'd27: a = 6'd48;
            6'd28: a = 6'd56; 6'd29: a = 6'd49; 6'd30: a = 6'd42; 6'd31: a = 6'd35;
            6'd32: a = 6'd28; 6'd33: a = 6'd21; 6'd34: a = 6'd14; 6'd35: a = 6'd7;
            6'd36: a = 6'd15; 6'd37: a = 6'd22; 6'd38: a = 6'd29; 6'd39: a = 6'd36;
            6'd40: a = 6'd43; 6'd41: a = 6'd50; 6'd42: a = 6'd57; 6'd43: a = 6'd58;
            6'd44: a = 6'd51; 6'd45: a = 6'd44; 6'd46: a = 6'd37; 6'd47: a = 6'd30;
            6'd48: a = 6'd23; 6'd49: a = 6'd31; 6'd50: a = 6'd38; 6'd51: a = 6'd45;
            6'd52: a = 6'd52; 6'd53: a = 6'd59; 6'd54: a = 6'd60; 6'd55: a = 6'd53;
            6'd56: a = 6'd46; 6'd57: a = 6'd39; 6'd58: a = 6'd47; 6'd59: a = 6'd54;
            6'd60: a = 6'd61; 6'd61: a = 6'd62; 6'd62: a = 6'd55; 6'd63: a = 6'd63;
            default: a = 6'd0;
        endcase
        return a;
    endfunction

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [5:0]        r_wr_cnt;
    logic [5:0]        r_rd_cnt;
    logic [1:0]        r_full;
    logic [1:0]        r_bmode;
    logic [DATA_W-1:0] r_mem [0:127];

    logic              w_acc;
    logic              w_con;
    logic              w_wr_mode;
    logic [6:0]        w_wr_addr;
    logic [6:0]        w_rd_addr;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;
    logic [1:0]        w_full_nxt;

    // Handshake status depends on registers only, so there is no ready/valid feed-through.
    assign rdy_out  = ~r_full[r_wr_bank];
    assign ena_out  = r_full[r_rd_bank];
    assign out_last = ena_out && (r_rd_cnt == 6'd63);
    assign out      = r_mem[w_rd_addr];

    // Transfer qualifiers, bank addressing and next occupancy of both banks.
    always_comb begin
        w_acc      = ena_in && rdy_out;
        w_con      = ena_out && rdy_in;
        w_wr_mode  = (r_wr_cnt == 6'd0) ? mode[0] : r_bmode[r_wr_bank];
        w_wr_addr  = {r_wr_bank, (w_wr_mode ? zz(r_wr_cnt) : r_wr_cnt)};
        w_rd_addr  = {r_rd_bank, (r_bmode[r_rd_bank] ? r_rd_cnt : zz(r_rd_cnt))};
        w_full_set = (w_acc && (r_wr_cnt == 6'd63)) ? (2'b01 << r_wr_bank) : 2'b00;
        w_full_clr = (w_con && (r_rd_cnt == 6'd63)) ? (2'b01 << r_rd_bank) : 2'b00;
        // A completing write and a completing read always target different banks.
        w_full_nxt = (r_full | w_full_set) & ~w_full_clr;
    end

    // Write/read counters, bank pointers, per-bank mode and fullness flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= 6'd0;
            r_rd_cnt  <= 6'd0;
            r_full    <= 2'b00;
            r_bmode   <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_acc) begin
                r_wr_cnt <= r_wr_cnt + 6'd1;
                if (r_wr_cnt == 6'd0) begin
                    r_bmode[r_wr_bank] <= mode[0];
                end
                if (r_wr_cnt == 6'd63) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_con) begin
                r_rd_cnt <= r_rd_cnt + 6'd1;
                if (r_rd_cnt == 6'd63) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    // Coefficient storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_mem[w_wr_addr] <= in;
        end
    end

endmodule

// File: tb/tb_zigzag_pp.sv
// Randomised scoreboard bench for zigzag_pp: a reference model of the zig-zag reorder
// queues expected outputs per block; a monitor pops and compares on every consume.
`timescale 1ns/1ps
module tb_zigzag_pp;
    localparam int DW  = 11;
    localparam int TMO = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena_in = 1'b0;
    logic          rdy_in = 1'b0;
    logic          rdy_out, ena_out, out_last;
    logic [DW-1:0] in_d = '0;
    logic [DW-1:0] out_d;
    logic [0:0]    mode_d = 1'b0;

    zigzag_pp #(.DATA_W(DW), .MODE_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena_in(ena_in), .rdy_out(rdy_out), .in(in_d),
        .mode(mode_d), .ena_out(ena_out), .rdy_in(rdy_in), .out(out_d), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int ZZ[64] = '{0, 8, 1, 2, 9,16,24,17,10, 3, 4,11,18,25,32,40,
                   33,26,19,12, 5, 6,13,20,27,34,41,48,56,49,42,35,
                   28,21,14, 7,15,22,29,36,43,50,57,58,51,44,37,30,
                   23,31,38,45,52,59,60,53,46,39,47,54,61,62,55,63};

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] cap_q[$];
    logic [DW-1:0] blk_in[64];
    logic [DW-1:0] orig[64];
    logic [DW:0]   mon_e;
    int errors = 0, checks = 0;
    int gap_pct = 0, rdy_mode = 2, consumed = 0, cyc = 0, rdy_drops = 0;
    bit watch_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rdy_in = 1'b1;
            1:       rdy_in = 1'($urandom_range(0, 1));
            default: rdy_in = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && watch_rdy && !rdy_out) rdy_drops++;
        if (rst_n && ena_out && rdy_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'(out_d), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out", int'(out_d), int'(mon_e[DW-1:0]));
                chk("out_last", int'(out_last), int'(mon_e[DW]));
            end
            cap_q.push_back(out_d);
            consumed++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: forward emits the block in zig-zag order; inverse places zig-zag slots
    // at their column-major positions and emits positions sequentially.
    task automatic push_block(input bit inv);
        logic [DW-1:0] m[64];
        if (!inv) begin
            for (int k = 0; k < 64; k++) exp_q.push_back({k == 63, blk_in[ZZ[k]]});
        end else begin
            for (int k = 0; k < 64; k++) m[ZZ[k]] = blk_in[k];
            for (int j = 0; j < 64; j++) exp_q.push_back({j == 63, m[j]});
        end
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic m);
        int t;
        while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
            ena_in = 1'b0;
            @(posedge clk);
            #1;
        end
        ena_in = 1'b1;
        in_d   = d;
        mode_d = m;
        t = 0;
        @(negedge clk);
        while (!rdy_out) begin
            t++;
            if (t > TMO) begin
                chk("accept_timeout", 0, 1);
                ena_in = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ena_in = 1'b0;
    endtask

    task automatic send_block(input bit inv, input int n);
        push_block(inv);
        for (int i = 0; i < n; i++) drive(blk_in[i], (i == 0) ? inv : 1'($urandom_range(0, 1)));
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < 64; i++) blk_in[i] = DW'(base + i);
    endtask

    task automatic fill_inv(input int base);
        for (int k = 0; k < 64; k++) blk_in[k] = DW'(base + ZZ[k]);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) blk_in[i] = DW'($urandom_range(0, 2047));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ena_in = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("rst_rdy_out", int'(rdy_out), 1);
            chk("rst_ena_out", int'(ena_out), 0);
            chk("rst_out_last", int'(out_last), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic scen1();
        rdy_mode = 0;
        gap_pct  = 0;
        fill_seq(100);
        @(negedge clk);
        chk("s1_idle_ena_out", int'(ena_out), 0);
        @(posedge clk);
        #1;
        send_block(1'b0, 64);
        chk("s1_latency_ena_out", int'(ena_out), 1);
        chk("s1_first_out", int'(out_d), 100);
        chk("s1_first_not_last", int'(out_last), 0);
        wait_drain();
    endtask

    initial begin
        int t0, c0;
        bit found;
        @(posedge clk);
        #1;
        do_reset();

        // 1: single forward block
        scen1();

        // 2: two forward blocks back-to-back, no input bubbles
        watch_rdy = 1'b1;
        t0 = cyc;
        fill_seq(100);
        send_block(1'b0, 64);
        fill_seq(200);
        send_block(1'b0, 64);
        chk("s2_cycles", cyc - t0, 128);
        watch_rdy = 1'b0;
        wait_drain();
        chk("s2_rdy_drops", rdy_drops, 0);

        // 3: downstream stalled, three blocks
        rdy_mode = 2;
        @(posedge clk);
        #1;
        fill_seq(100);
        send_block(1'b0, 64);
        fill_seq(200);
        send_block(1'b0, 64);
        chk("s3_rdy_out_full", int'(rdy_out), 0);
        chk("s3_ena_out", int'(ena_out), 1);
        chk("s3_out_hold", int'(out_d), 100);
        fill_seq(300);
        fork
            send_block(1'b0, 64);
        join_none
        repeat (5) begin
            @(negedge clk);
            chk("s3_out_stable", int'(out_d), 100);
            chk("s3_rdy_out_low", int'(rdy_out), 0);
        end
        rdy_mode = 0;
        found = 1'b0;
        for (int t = 0; t < TMO && !found; t++) begin
            @(negedge clk);
            if (ena_out && rdy_in && out_last) begin
                chk("s3_rdy_before_free", int'(rdy_out), 0);
                @(negedge clk);
                chk("s3_rdy_after_free", int'(rdy_out), 1);
                found = 1'b1;
            end
        end
        if (!found) chk("s3_last_timeout", 0, 1);
        wait fork;
        wait_drain();

        // 4: inverse block, then mixed modes under random backpressure
        fill_inv(300);
        send_block(1'b1, 64);
        wait_drain();
        rdy_mode = 1;
        fill_seq(400);
        send_block(1'b0, 64);
        fill_inv(500);
        send_block(1'b1, 64);
        fill_seq(600);
        send_block(1'b0, 64);
        wait_drain();

        // 5: forward then inverse round trip restores the original block
        rdy_mode = 0;
        fill_rand();
        for (int i = 0; i < 64; i++) orig[i] = blk_in[i];
        cap_q.delete();
        send_block(1'b0, 64);
        wait_drain();
        chk("s5_fwd_count", cap_q.size(), 64);
        for (int i = 0; i < 64; i++) blk_in[i] = (i < cap_q.size()) ? cap_q[i] : '0;
        cap_q.delete();
        send_block(1'b1, 64);
        wait_drain();
        chk("s5_inv_count", cap_q.size(), 64);
        for (int i = 0; i < 64 && i < cap_q.size(); i++) chk("s5_roundtrip", int'(cap_q[i]), int'(orig[i]));

        // 6: reset mid-write and mid-read, then fresh block and random traffic
        fill_seq(100);
        send_block(1'b0, 40);
        do_reset();
        scen1();
        rdy_mode = 1;
        fill_rand();
        send_block(1'b0, 64);
        c0 = consumed;
        for (int t = 0; t < TMO && consumed < c0 + 20; t++) @(negedge clk);
        chk("s6_partial_read", int'(consumed >= c0 + 20), 1);
        @(posedge clk);
        #1;
        do_reset();
        scen1();
        gap_pct  = 30;
        rdy_mode = 1;
        for (int b = 0; b < 6; b++) begin
            fill_rand();
            send_block(1'($urandom_range(0, 1)), 64);
        end
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
